// File: rtl/fsm_color_sequencer.sv
// One-hot colour sequencer driven by an internal dwell timer.
// Run modes: auto-forward, ping-pong, manual step and blink.
module fsm_color_sequencer #(
    parameter int NUM_COLORS = 3,
    parameter int DWELL_W    = 8,
    localparam int IDX_W     = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  In,
    input  logic [1:0]            mode,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [NUM_COLORS-1:0] color,
    output logic [IDX_W-1:0]      index,
    output logic                  step
);

    typedef enum logic [1:0] {
        AUTO_FWD = 2'b00,
        PINGPONG = 2'b01,
        MANUAL   = 2'b10,
        BLINK    = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_COLORS - 1);
    localparam logic [IDX_W-1:0]   ONE_IDX  = IDX_W'(1);
    localparam logic [DWELL_W-1:0] ONE_DW   = DWELL_W'(1);

    mode_e                  mode_q, mode_q_n, mode_req;
    dir_e                   dir, dir_n;
    logic [DWELL_W-1:0]     timer, timer_n;
    logic [DWELL_W-1:0]     dwell_eff;
    logic [IDX_W-1:0]       index_n;
    logic [NUM_COLORS-1:0]  color_n;
    logic                   step_n;
    logic                   blink_on, blink_n;
    logic                   in_q, in_q_n;
    logic                   run, tc;

    function automatic logic [NUM_COLORS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_COLORS-1:0] v;
        for (int i = 0; i < NUM_COLORS; i++) begin
            v[i] = (idx == IDX_W'(i));
        end
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] fwd(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + ONE_IDX;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q   <= mode_e'(mode);
            dir      <= DIR_UP;
            timer    <= '0;
            index    <= '0;
            color    <= onehot('0);
            step     <= 1'b0;
            blink_on <= 1'b1;
            in_q     <= 1'b0;
        end else begin
            mode_q   <= mode_q_n;
            dir      <= dir_n;
            timer    <= timer_n;
            index    <= index_n;
            color    <= color_n;
            step     <= step_n;
            blink_on <= blink_n;
            in_q     <= in_q_n;
        end
    end

    always_comb begin
        mode_req  = mode_e'(mode);
        mode_q_n  = mode_q;
        dir_n     = dir;
        timer_n   = timer;
        index_n   = index;
        step_n    = 1'b0;
        blink_n   = blink_on;
        in_q_n    = In;
        dwell_eff = (dwell == '0) ? ONE_DW : dwell;
        run       = In && (mode_q != MANUAL);
        // >= rather than == so a shrinking dwell terminates at once instead of wrapping
        tc        = run && (timer >= dwell_eff - ONE_DW);

        if (mode_req != mode_q) begin
            mode_q_n = mode_req;
            timer_n  = '0;
            blink_n  = 1'b1;
            dir_n    = DIR_UP;
        end else if (mode_q == MANUAL) begin
            timer_n = '0;
            if (In && !in_q) begin
                index_n = fwd(index);
                step_n  = 1'b1;
            end
        end else if (tc) begin
            timer_n = '0;
            step_n  = 1'b1;
            case (mode_q)
                AUTO_FWD: index_n = fwd(index);
                PINGPONG: begin
                    if (NUM_COLORS == 1) begin
                        index_n = '0;
                    end else if (dir == DIR_UP) begin
                        if (index == LAST_IDX) begin
                            index_n = LAST_IDX - ONE_IDX;
                            dir_n   = DIR_DOWN;
                        end else begin
                            index_n = index + ONE_IDX;
                        end
                    end else begin
                        if (index == '0) begin
                            index_n = ONE_IDX;
                            dir_n   = DIR_UP;
                        end else begin
                            index_n = index - ONE_IDX;
                        end
                    end
                end
                BLINK:    blink_n = !blink_on;
                default:  index_n = index;
            endcase
        end else if (run) begin
            timer_n = timer + ONE_DW;
        end

        // Off-phase only exists while blinking; any other mode shows the lit colour
        color_n = (mode_q_n == BLINK && !blink_n) ? '0 : onehot(index_n);
    end

endmodule
